// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU stream wrapper: op codes, rounding modes,
// flag bit positions and the canonical quiet NaN returned for illegal ops.
package fpu_pkg;

   localparam logic [2:0] FPU_ADD = 3'd0;
   localparam logic [2:0] FPU_SUB = 3'd1;
   localparam logic [2:0] FPU_MUL = 3'd2;
   localparam logic [2:0] FPU_DIV = 3'd3;
   localparam logic [2:0] FPU_I2F = 3'd4;
   localparam logic [2:0] FPU_F2I = 3'd5;

   localparam logic [1:0] RM_NEAREST = 2'd0;
   localparam logic [1:0] RM_ZERO    = 2'd1;
   localparam logic [1:0] RM_UP      = 2'd2;
   localparam logic [1:0] RM_DOWN    = 2'd3;

   localparam int FLAG_INF         = 7;
   localparam int FLAG_SNAN        = 6;
   localparam int FLAG_QNAN        = 5;
   localparam int FLAG_INE         = 4;
   localparam int FLAG_OVERFLOW    = 3;
   localparam int FLAG_UNDERFLOW   = 2;
   localparam int FLAG_ZERO        = 1;
   localparam int FLAG_DIV_BY_ZERO = 0;

   localparam logic [31:0] QNAN_CANON    = 32'h7FC0_0000;
   localparam logic [7:0]  ILLEGAL_FLAGS = 8'h20;

   typedef logic [7:0] fpu_flags_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= FPU_F2I;
   endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Order-preserving result FIFO; the head entry is presented combinationally
// from the storage array and a pop on an empty FIFO is ignored.
module fpu_res_fifo
   import fpu_pkg::*;
#(
   parameter int DW    = 44,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_rd;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(do_rd);
      end
   end

   // Credits upstream keep this from ever firing in a correct system.
   assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full))
      else $error("fpu_res_fifo write while full");

endmodule

// File: rtl/fpu_stream_wrapper.sv
// Valid/ready front end for the fixed-latency FPU core: a delay line follows
// each accepted op to the core output, results queue in an order-keeping FIFO.
module fpu_stream_wrapper
   import fpu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 4,
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [1:0]       in_rmode,
   input  logic [WIDTH-1:0] in_opa,
   input  logic [WIDTH-1:0] in_opb,
   input  logic [TAG_W-1:0] in_tag,
   output logic [2:0]       core_fpu_op,
   output logic [1:0]       core_rmode,
   output logic [WIDTH-1:0] core_opa,
   output logic [WIDTH-1:0] core_opb,
   input  logic [WIDTH-1:0] core_out,
   input  logic [7:0]       core_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [7:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic [7:0]       flag_sticky,
   input  logic             flag_clr
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(LATENCY + 2);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      fpu_flags_t       flags;
      logic [TAG_W-1:0] tag;
   } fpu_res_t;

   logic             accept;
   logic             wr_en;
   logic             ready_en;
   logic             fifo_empty;
   logic [LATENCY:0] dl_valid;
   logic [LATENCY:0] dl_ill;
   logic [TAG_W-1:0] dl_tag [LATENCY+1];
   logic [IW-1:0]    inflight;
   logic [CW-1:0]    fifo_count;
   fpu_res_t         wr_res;
   fpu_res_t         head;

   // Credits come only from registered counts, so in_ready never depends on out_ready.
   assign in_ready = ready_en && ((int'(inflight) + int'(fifo_count)) < DEPTH);
   assign accept   = in_valid && in_ready;
   assign wr_en    = dl_valid[LATENCY];

   always_comb begin
      wr_res.tag = dl_tag[LATENCY];
      if (dl_ill[LATENCY]) begin
         wr_res.result = WIDTH'(QNAN_CANON);
         wr_res.flags  = ILLEGAL_FLAGS;
      end else begin
         wr_res.result = core_out;
         wr_res.flags  = core_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en    <= 1'b0;
         dl_valid    <= '0;
         dl_ill      <= '0;
         inflight    <= '0;
         for (int i = 0; i <= LATENCY; i++) dl_tag[i] <= '0;
         core_fpu_op <= '0;
         core_rmode  <= '0;
         core_opa    <= '0;
         core_opb    <= '0;
      end else begin
         ready_en  <= 1'b1;
         dl_valid  <= {dl_valid[LATENCY-1:0], accept};
         dl_ill    <= {dl_ill[LATENCY-1:0], accept && !op_legal(in_op)};
         dl_tag[0] <= in_tag;
         for (int i = 1; i <= LATENCY; i++) dl_tag[i] <= dl_tag[i-1];
         inflight  <= inflight + IW'(accept) - IW'(wr_en);
         // Illegal ops leave the core inputs untouched; their slot is patched at write.
         if (accept && op_legal(in_op)) begin
            core_fpu_op <= in_op;
            core_rmode  <= in_rmode;
            core_opa    <= in_opa;
            core_opb    <= in_opb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flag_sticky <= '0;
      else        flag_sticky <= (flag_clr ? 8'h00 : flag_sticky) | (wr_en ? wr_res.flags : 8'h00);
   end

   fpu_res_fifo #(
      .DW    ($bits(fpu_res_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_res),
      .rd_en   (out_ready),
      .rd_data (head),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_valid  = !fifo_empty;
   assign out_result = head.result;
   assign out_flags  = head.flags;
   assign out_tag    = head.tag;

endmodule

// File: tb/tb_fpu_stream_wrapper.sv
// Scoreboard bench for fpu_stream_wrapper with a behavioural fixed-latency
// core stand-in; expectations are pushed at accept and popped at output.
module tb_fpu_stream_wrapper;
   import fpu_pkg::*;

   localparam int LATENCY = 4;
   localparam int DEPTH   = 8;

   typedef struct packed {
      logic [31:0] result;
      logic [7:0]  flags;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  in_op;
   logic [1:0]  in_rmode;
   logic [31:0] in_opa, in_opb;
   logic [3:0]  in_tag;
   logic [2:0]  core_fpu_op;
   logic [1:0]  core_rmode;
   logic [31:0] core_opa, core_opb, core_out;
   logic [7:0]  core_flags;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [7:0]  out_flags;
   logic [3:0]  out_tag;
   logic [7:0]  flag_sticky;
   logic        flag_clr;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   rdy_mode = 0;
   logic [7:0] sticky_exp = 8'h00;
   exp_t sb[$];
   exp_t mon_e;

   fpu_stream_wrapper #(.WIDTH(32), .LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rmode(in_rmode),
      .in_opa(in_opa), .in_opb(in_opb), .in_tag(in_tag),
      .core_fpu_op(core_fpu_op), .core_rmode(core_rmode), .core_opa(core_opa), .core_opb(core_opb),
      .core_out(core_out), .core_flags(core_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .out_tag(out_tag),
      .flag_sticky(flag_sticky), .flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   // Stand-in arithmetic: exact for the directed cases, a deterministic hash otherwise.
   function automatic logic [39:0] core_fn(input logic [2:0] op, input logic [1:0] rm,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [7:0]  f;
      f = (a[0] & b[0]) ? 8'h10 : 8'h00;
      r = (a ^ {b[15:0], b[31:16]}) + {27'd0, op, rm};
      if (op == FPU_ADD && a == 32'h3F800000 && b == 32'h40000000) begin
         r = 32'h40400000; f = 8'h00;
      end else if (op == FPU_MUL && a == 32'h40000000 && b == 32'h40000000) begin
         r = 32'h40800000; f = 8'h00;
      end else if (op == FPU_DIV && b == 32'h0) begin
         r = {a[31], 31'h7F800000}; f = 8'h81;
      end
      return {f, r};
   endfunction

   logic [39:0] core_pipe [LATENCY];
   always @(posedge clk) begin
      core_pipe[0] <= core_fn(core_fpu_op, core_rmode, core_opa, core_opb);
      for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_out   = core_pipe[LATENCY-1][31:0];
   assign core_flags = core_pipe[LATENCY-1][39:32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t, output int waited);
      exp_t e;
      waited   = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_rmode = rm;
      in_opa   = a;
      in_opb   = b;
      in_tag   = t;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: tag %0h not accepted within 100 cycles", t);
         in_valid = 1'b0;
      end else begin
         if (op <= 3'd5) {e.flags, e.result} = core_fn(op, rm, a, b);
         else begin
            e.result = 32'h7FC00000;
            e.flags  = 8'h20;
         end
         e.tag = t;
         sb.push_back(e);
         sticky_exp |= e.flags;
      end
      @(negedge clk);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, out_valid, 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(name, sb.size(), 0);
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_unexpected: tag %0h result %0h with nothing outstanding", out_tag, out_result);
         end else begin
            mon_e = sb.pop_front();
            chk("out_result", out_result, mon_e.result);
            chk("out_flags", out_flags, mon_e.flags);
            chk("out_tag", out_tag, mon_e.tag);
         end
      end
   end

   initial begin
      int w, total, seen, cnt;
      logic [31:0] a1, b1;
      rst_n = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rmode = 2'd0;
      in_opa = 32'h0; in_opb = 32'h0; in_tag = 4'h0; flag_clr = 1'b0;
      #1 rst_n = 1'b0;
      in_valid = 1'b1; in_op = FPU_MUL; in_opa = 32'h12345678; in_opb = 32'h9ABCDEF0; in_tag = 4'h7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_in_ready", in_ready, 0);
      end
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sticky", flag_sticky, 0);
      chk("reset_core_op", core_fpu_op, 0);
      chk("reset_core_opa", core_opa, 0);
      chk("reset_core_opb", core_opb, 0);
      chk("reset_out_result", out_result, 0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_release", in_ready, 1);

      // single add and its accept-to-valid latency
      rdy_mode = 1;
      send(FPU_ADD, RM_NEAREST, 32'h3F800000, 32'h40000000, 4'd3, w);
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("add_latency", cnt, LATENCY + 1);
      chk("add_result", out_result, 32'h40400000);
      chk("add_tag", out_tag, 3);
      drain("add_drain");

      // backpressure: credits run out after DEPTH accepts
      rdy_mode = 0;
      total = 0;
      for (int i = 0; i < 8; i++) begin
         send(FPU_ADD, RM_ZERO, 32'(i) << 4, 32'h100, 4'(i), w);
         total += w;
      end
      chk("bp_accept_stall", total, 0);
      in_tag = 4'd8;
      seen = 0;
      for (int i = 0; i < LATENCY + 3; i++) begin
         if (in_ready) seen++;
         @(negedge clk);
      end
      chk("bp_ready_low", seen, 0);
      in_valid = 1'b0;
      rdy_mode = 1;
      @(negedge clk);
      chk("bp_ready_before_pop", in_ready, 0);
      @(negedge clk);
      chk("bp_ready_after_pop", in_ready, 1);
      send(FPU_ADD, RM_ZERO, 32'h80, 32'h100, 4'd8, w);
      send(FPU_ADD, RM_ZERO, 32'h90, 32'h100, 4'd9, w);
      in_valid = 1'b0;
      drain("bp_drain");

      // divide by zero, then a clear coinciding with an inexact write
      send(FPU_DIV, RM_NEAREST, 32'h3F800000, 32'h0, 4'd5, w);
      in_valid = 1'b0;
      wait_valid("div_wait");
      chk("div_result", out_result, 32'h7F800000);
      chk("div_flags", out_flags, 8'h81);
      chk("div_sticky", flag_sticky, 8'h81);
      drain("div_drain");
      send(FPU_ADD, RM_NEAREST, 32'h1, 32'h1, 4'd6, w);
      in_valid = 1'b0;
      repeat (LATENCY) @(negedge clk);
      chk("sticky_before_clr", flag_sticky, 8'h81);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      chk("ine_written", out_valid, 1);
      chk("sticky_clr_keeps_new", flag_sticky, 8'h10);
      drain("ine_drain");

      // illegal op between legal ones
      a1 = 32'h3F800000;
      b1 = 32'h40000000;
      send(FPU_ADD, RM_UP, a1, b1, 4'd1, w);
      send(3'd6, RM_DOWN, 32'hDEADBEEF, 32'hCAFEF00D, 4'd2, w);
      chk("illegal_core_op", core_fpu_op, FPU_ADD);
      chk("illegal_core_rmode", core_rmode, RM_UP);
      chk("illegal_core_opa", core_opa, a1);
      chk("illegal_core_opb", core_opb, b1);
      send(FPU_MUL, RM_NEAREST, 32'h40000000, 32'h40000000, 4'd3, w);
      in_valid = 1'b0;
      chk("mul_core_op", core_fpu_op, FPU_MUL);
      drain("illegal_drain");

      // randomized traffic with random output stalls
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      sticky_exp = 8'h00;
      rdy_mode = 2;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end else begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, 4'($urandom_range(0, 15)), w);
         end
      end
      in_valid = 1'b0;
      rdy_mode = 1;
      drain("rand_drain");
      chk("rand_sticky", flag_sticky, sticky_exp);

      // reset while results are buffered and in flight
      rdy_mode = 0;
      send(FPU_SUB, RM_NEAREST, 32'h11, 32'h22, 4'hA, w);
      send(FPU_I2F, RM_NEAREST, 32'h33, 32'h44, 4'hB, w);
      send(FPU_F2I, RM_NEAREST, 32'h55, 32'h66, 4'hC, w);
      in_valid = 1'b0;
      wait_valid("mf_wait");
      rst_n = 1'b0;
      #1;
      chk("mf_out_valid", out_valid, 0);
      chk("mf_in_ready", in_ready, 0);
      chk("mf_out_tag", out_tag, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdy_mode = 1;
      seen = 0;
      repeat (2 * LATENCY + 2) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mf_no_stale", seen, 0);
      chk("mf_ready", in_ready, 1);
      chk("mf_sticky", flag_sticky, 0);
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
